// File: rtl/regbank4_we_if.sv
// regbank4_we_if
// Bundles the write and read signals of the four-entry register bank.
//   we       write enables, one-hot or zero when well formed
//   wdata    write data
//   raddr_a  read address, port A
//   raddr_b  read address, port B
//   rdata_a  read data, port A (combinational, write-through bypass)
//   rdata_b  read data, port B (combinational, write-through bypass)
//   rvalid_a entry behind port A holds data or is being written now
//   rvalid_b same for port B
//   valid    per-entry written flags (registered)
//   err      sticky multi-hot write flag (registered)
// master drives writes/addresses; slave is the register bank.
interface regbank4_we_if #(
    parameter int WIDTH = 64
);
    logic [3:0]       we;
    logic [WIDTH-1:0] wdata;
    logic [1:0]       raddr_a;
    logic [1:0]       raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             rvalid_a;
    logic             rvalid_b;
    logic [3:0]       valid;
    logic             err;

    modport master (
        output we, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b, rvalid_a, rvalid_b, valid, err
    );

    modport slave (
        input  we, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b, rvalid_a, rvalid_b, valid, err
    );
endinterface

// File: rtl/regbank4_we.sv
// regbank4_we
// Four-entry register bank written through one-hot enables from the
// upstream 2-to-4 address decoder. Two combinational read ports return
// wdata directly when they address the entry being legally written this
// cycle. A write with more than one enable bit set is dropped and sets a
// sticky error flag that only reset clears.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    regbank4_we_if slave modport (write, read and status signals)
module regbank4_we #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    regbank4_we_if.slave       bus
);

    // Number of set bits in a 4-bit enable vector.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cnt = cnt + {2'd0, v[i]};
        end
        return cnt;
    endfunction

    logic [WIDTH-1:0] mem_q [4];
    logic [WIDTH-1:0] mem_d [4];
    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic             err_q;
    logic             err_d;

    logic [2:0]       we_cnt_s;
    logic             legal_s;
    logic             illegal_s;

    assign we_cnt_s  = popcount4(bus.we);
    assign legal_s   = (we_cnt_s == 3'd1);
    assign illegal_s = (we_cnt_s >= 3'd2);

    // Next-state: a legal write updates exactly one entry; multi-hot only sets err.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (legal_s) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.we[i]) begin
                    mem_d[i]   = bus.wdata;
                    valid_d[i] = 1'b1;
                end else begin
                    mem_d[i]   = mem_q[i];
                    valid_d[i] = valid_q[i];
                end
            end
        end else if (illegal_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Read port A; bypass only on a legal write, so malformed enables never leak wdata.
    always_comb begin
        if (legal_s && bus.we[bus.raddr_a]) begin
            bus.rdata_a  = bus.wdata;
            bus.rvalid_a = 1'b1;
        end else begin
            bus.rdata_a  = mem_q[bus.raddr_a];
            bus.rvalid_a = valid_q[bus.raddr_a];
        end
    end

    // Read port B; same rule as port A.
    always_comb begin
        if (legal_s && bus.we[bus.raddr_b]) begin
            bus.rdata_b  = bus.wdata;
            bus.rvalid_b = 1'b1;
        end else begin
            bus.rdata_b  = mem_q[bus.raddr_b];
            bus.rvalid_b = valid_q[bus.raddr_b];
        end
    end

    assign bus.valid = valid_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_regbank4_we.sv
module tb_regbank4_we;

    localparam int WIDTH = 64;

    logic clk;
    logic reset;

    regbank4_we_if #(.WIDTH(WIDTH)) bus ();

    regbank4_we #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] rd_a;
        logic             rv_a;
        logic [WIDTH-1:0] rd_b;
        logic             rv_b;
        logic [3:0]       valid;
        logic             err;
    } exp_t;

    exp_t sb[$];

    // Reference model of the bank state
    logic [WIDTH-1:0] m_mem [4];
    logic [3:0]       m_valid;
    logic             m_err;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the expected outputs, check them mid-cycle, then advance the model at the edge.
    task automatic step(input logic r, input logic [3:0] w, input logic [WIDTH-1:0] d,
                        input logic [1:0] a, input logic [1:0] b, input string tag);
        exp_t e;
        exp_t got;
        logic legal;
        @(negedge clk);
        reset       = r;
        bus.we      = w;
        bus.wdata   = d;
        bus.raddr_a = a;
        bus.raddr_b = b;
        legal = ($countones(w) == 1);
        e.tag   = tag;
        e.rd_a  = (legal && w[a]) ? d : m_mem[a];
        e.rv_a  = (legal && w[a]) ? 1'b1 : m_valid[a];
        e.rd_b  = (legal && w[b]) ? d : m_mem[b];
        e.rv_b  = (legal && w[b]) ? 1'b1 : m_valid[b];
        e.valid = m_valid;
        e.err   = m_err;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            got = sb.pop_front();
            chk({got.tag, ".rdata_a"},  bus.rdata_a, got.rd_a);
            chk({got.tag, ".rvalid_a"}, {63'd0, bus.rvalid_a}, {63'd0, got.rv_a});
            chk({got.tag, ".rdata_b"},  bus.rdata_b, got.rd_b);
            chk({got.tag, ".rvalid_b"}, {63'd0, bus.rvalid_b}, {63'd0, got.rv_b});
            chk({got.tag, ".valid"},    {60'd0, bus.valid}, {60'd0, got.valid});
            chk({got.tag, ".err"},      {63'd0, bus.err}, {63'd0, got.err});
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) m_mem[i] = '0;
            m_valid = 4'b0000;
            m_err   = 1'b0;
        end else if ($countones(w) == 1) begin
            for (int i = 0; i < 4; i++) begin
                if (w[i]) begin
                    m_mem[i]   = d;
                    m_valid[i] = 1'b1;
                end
            end
        end else if ($countones(w) >= 2) begin
            m_err = 1'b1;
        end
    endtask

    initial begin
        logic [3:0]       rw;
        logic [WIDTH-1:0] rd;
        logic             rr;

        reset       = 1'b1;
        bus.we      = 4'b0000;
        bus.wdata   = '0;
        bus.raddr_a = 2'd0;
        bus.raddr_b = 2'd0;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 4; i++) m_mem[i] = '0;
        m_valid = 4'b0000;
        m_err   = 1'b0;

        // Reset then read
        step(1'b0, 4'b0000, 64'h0, 2'd0, 2'd1, "rst_rd01");
        step(1'b0, 4'b0000, 64'h0, 2'd2, 2'd3, "rst_rd23");

        // Legal fill
        step(1'b0, 4'b0001, 64'h11, 2'd0, 2'd1, "fill0");
        step(1'b0, 4'b0010, 64'h22, 2'd1, 2'd0, "fill1");
        step(1'b0, 4'b0100, 64'h33, 2'd2, 2'd3, "fill2");
        step(1'b0, 4'b1000, 64'h44, 2'd3, 2'd2, "fill3");
        step(1'b0, 4'b0000, 64'h0, 2'd0, 2'd1, "fill_rd01");
        chk("fill_const_a0", bus.rdata_a, 64'h11);
        chk("fill_const_b1", bus.rdata_b, 64'h22);
        step(1'b0, 4'b0000, 64'h0, 2'd2, 2'd3, "fill_rd23");
        chk("fill_const_a2", bus.rdata_a, 64'h33);
        chk("fill_const_b3", bus.rdata_b, 64'h44);
        chk("fill_const_valid", {60'd0, bus.valid}, 64'hF);

        // Bypass
        step(1'b0, 4'b0100, 64'hAB, 2'd2, 2'd1, "bypass");
        step(1'b0, 4'b0000, 64'h0, 2'd2, 2'd2, "bypass_after");
        chk("bypass_const_a2", bus.rdata_a, 64'hAB);

        // Multi-hot: dropped, no bypass, sticky err
        step(1'b0, 4'b0011, 64'hFF, 2'd0, 2'd1, "mhot2");
        step(1'b0, 4'b0000, 64'h0, 2'd0, 2'd1, "mhot_after");
        chk("mhot_const_a0", bus.rdata_a, 64'h11);
        chk("mhot_const_err", {63'd0, bus.err}, 64'd1);
        step(1'b0, 4'b1111, 64'hEE, 2'd3, 2'd2, "mhot4");
        step(1'b0, 4'b1101, 64'hDD, 2'd0, 2'd3, "mhot3");
        step(1'b0, 4'b0001, 64'h99, 2'd0, 2'd3, "legal_err_sticky");
        step(1'b0, 4'b0000, 64'h0, 2'd0, 2'd1, "err_still");

        // Reset collision: bypass while held, write discarded
        step(1'b1, 4'b1000, 64'h55, 2'd3, 2'd3, "rst_collide");
        step(1'b0, 4'b0000, 64'h0, 2'd3, 2'd0, "rst_collide_after");
        chk("collide_const_a3", bus.rdata_a, 64'h0);
        chk("collide_const_err", {63'd0, bus.err}, 64'd0);

        // Overwrite same entry back to back
        step(1'b0, 4'b0010, 64'h10, 2'd1, 2'd1, "ovw1");
        step(1'b0, 4'b0010, 64'h20, 2'd1, 2'd0, "ovw2");
        step(1'b0, 4'b0000, 64'h0, 2'd1, 2'd1, "ovw_rd");
        chk("ovw_const_a1", bus.rdata_a, 64'h20);
        chk("ovw_const_valid", {60'd0, bus.valid}, 64'h2);

        // Random mix including multi-hot and occasional reset
        for (int k = 0; k < 60; k++) begin
            rw = 4'($urandom_range(0, 15));
            rd = {$urandom, $urandom};
            rr = ($urandom_range(0, 19) == 0);
            step(rr, rw, rd, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "rand");
        end

        step(1'b0, 4'b0000, 64'h0, 2'd0, 2'd0, "final");
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
